// File: rtl/vga_tile_mem_arbiter_if.sv
// rtl/vga_tile_mem_arbiter_if.sv - game-logic write request/grant handshake
// Purpose: carries one tile write from the game engine (master) to the tile
//   RAM arbiter (slave).
// Signals:
//   wr_req   master->slave  write request, held until wr_gnt
//   wr_addr  master->slave  tile address, stable while wr_req is high
//   wr_data  master->slave  tile code, stable while wr_req is high
//   wr_gnt   slave->master  1-clk pulse, write accepted this cycle
interface vga_tile_mem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 4
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_gnt);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_gnt);
endinterface

// File: rtl/vga_tile_mem_arbiter.sv
// rtl/vga_tile_mem_arbiter.sv - single-port tile RAM arbiter, display fetch vs game writes
// Purpose: shares one tile RAM between the VGA tile fetch (absolute priority,
//   fixed latency), an optional full-board clear sweep, and game writes.
// Optional feature: define TILE_ARB_CLEAR_EN to build the clear sweep.
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   pix_en             1-clk pulse per pixel
//   hcount, vcount     current pixel column / line from the timing generator
//   fetch_tile/_vld    fetched tile code (held) and its 1-clk update strobe
//   wr                 game write handshake (slave modport)
//   clear_req/_busy    start pulse / in-progress flag of the clear sweep
//   mem_addr/_we/_wdata registered tile RAM command
//   mem_rdata          tile RAM read data, 1-clk latency
module vga_tile_mem_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int H_TOTAL    = 800,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  parameter int TILE_SHIFT = 4,
  parameter int COLS       = H_ACTIVE >> TILE_SHIFT,
  parameter int ROWS       = V_ACTIVE >> TILE_SHIFT,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pix_en,
  input  logic [9:0]             hcount,
  input  logic [9:0]             vcount,
  output logic [DATA_W-1:0]      fetch_tile,
  output logic                   fetch_vld,
  vga_tile_mem_arbiter_if.slave  wr,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata
);

  localparam logic [9:0] H_ACT_M1 = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_TOT    = 10'(H_TOTAL);
  localparam logic [9:0] H_TOT_M1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_TOT    = 10'(V_TOTAL);
  localparam logic [9:0] V_TOT_M1 = 10'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_TILE = ADDR_W'(COLS * ROWS - 1);
  localparam logic [TILE_SHIFT-1:0] TILE_END = '1;

  typedef enum logic [1:0] {IDLE, FETCH, FETCH_WAIT, WRITE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   fetch_tile_q, fetch_tile_d;
  logic                fetch_vld_q, fetch_vld_d;
  logic                wr_gnt_q, wr_gnt_d;

  // Fetch slot: the last pixel of a tile, when the following pixel is visible.
  logic                slot;
  logic [9:0]          h_next, v_next, f_col, f_row;
  logic [ADDR_W-1:0]   slot_addr;

  always_comb begin
    slot   = 1'b0;
    f_col  = '0;
    f_row  = '0;
    h_next = hcount + 10'd1;
    v_next = (vcount == V_TOT_M1) ? 10'd0 : vcount + 10'd1;
    if (pix_en && hcount < H_TOT && vcount < V_TOT &&
        hcount[TILE_SHIFT-1:0] == TILE_END) begin
      if (hcount < H_ACT_M1) begin
        f_col = h_next >> TILE_SHIFT;
        f_row = vcount >> TILE_SHIFT;
        slot  = vcount < V_ACT;
      end else if (hcount == H_TOT_M1) begin
        // End of line: prefetch column 0 of the next line (wraps at frame end).
        f_row = v_next >> TILE_SHIFT;
        slot  = v_next < V_ACT;
      end
    end
  end

  assign slot_addr = ADDR_W'(f_row) * COLS_A + ADDR_W'(f_col);

`ifdef TILE_ARB_CLEAR_EN
  logic              clr_busy_q, clr_busy_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_step;

  // A clear write takes any cycle the port is free and no fetch slot claims it.
  assign clr_step = clr_busy_q && !slot && (state_q == IDLE || state_q == WRITE);

  always_comb begin
    clr_busy_d = clr_busy_q;
    clr_cnt_d  = clr_cnt_q;
    if (!clr_busy_q) begin
      if (clear_req) begin
        clr_busy_d = 1'b1;
        clr_cnt_d  = '0;
      end
    end else if (clr_step) begin
      if (clr_cnt_q == LAST_TILE) begin
        clr_busy_d = 1'b0;
        clr_cnt_d  = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_busy_q <= 1'b0;
      clr_cnt_q  <= '0;
    end else begin
      clr_busy_q <= clr_busy_d;
      clr_cnt_q  <= clr_cnt_d;
    end
  end

  assign clear_busy = clr_busy_q;
`else
  logic [ADDR_W:0] unused_sigs;
  assign unused_sigs = {clear_req, LAST_TILE};
  assign clear_busy  = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    fetch_tile_d = fetch_tile_q;
    fetch_vld_d  = 1'b0;
    wr_gnt_d     = 1'b0;
    case (state_q)
      FETCH: state_d = FETCH_WAIT;
      FETCH_WAIT: begin
        fetch_tile_d = mem_rdata;
        fetch_vld_d  = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        // IDLE or WRITE: the port is free next cycle. A slot may land on the
        // WRITE cycle, so fetches are accepted there too.
        state_d = IDLE;
        if (slot) begin
          state_d    = FETCH;
          mem_addr_d = slot_addr;
`ifdef TILE_ARB_CLEAR_EN
        end else if (clr_busy_q) begin
          mem_addr_d  = clr_cnt_q;
          mem_we_d    = 1'b1;
          mem_wdata_d = '0;
`endif
        end else if (state_q == IDLE && wr.wr_req) begin
          // Only from IDLE: the WRITE cycle spaces grants at least 2 clks apart.
          state_d     = WRITE;
          mem_addr_d  = wr.wr_addr;
          mem_wdata_d = wr.wr_data;
          mem_we_d    = 1'b1;
          wr_gnt_d    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      fetch_tile_q <= '0;
      fetch_vld_q  <= 1'b0;
      wr_gnt_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      fetch_tile_q <= fetch_tile_d;
      fetch_vld_q  <= fetch_vld_d;
      wr_gnt_q     <= wr_gnt_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign fetch_tile = fetch_tile_q;
  assign fetch_vld  = fetch_vld_q;
  assign wr.wr_gnt  = wr_gnt_q;

endmodule

// File: tb/tb_vga_tile_mem_arbiter.sv
// tb/tb_vga_tile_mem_arbiter.sv - scoreboard bench for vga_tile_mem_arbiter
module tb_vga_tile_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [9:0]  hcount = '0;
  logic [9:0]  vcount = '0;
  logic [3:0]  fetch_tile;
  logic        fetch_vld;
  logic        clear_req = 1'b0;
  logic        clear_busy;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata;

  vga_tile_mem_arbiter_if wr_if ();

  vga_tile_mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .hcount     (hcount),
    .vcount     (vcount),
    .fetch_tile (fetch_tile),
    .fetch_vld  (fetch_vld),
    .wr         (wr_if),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [3:0] ram    [0:2047];
  logic [3:0] shadow [0:2047];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct packed {
    logic [10:0] a;
    logic [3:0]  d;
    logic        g;
  } wexp_t;

  typedef struct {
    int h;
    int v;
    int pe;
    int a;
  } slot_t;

  logic [3:0] fq[$];
  wexp_t      wq[$];
  slot_t      tbl[$];
  wexp_t      mon_w;

  int checks = 0;
  int errors = 0;
  int fetch_seen = 0;
  int gnt_seen = 0;
  int gnt_adj = 0;
  logic prev_gnt = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int a, input int d, input logic g);
    wexp_t w;
    w.a = 11'(a);
    w.d = 4'(d);
    w.g = g;
    wq.push_back(w);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = 1'b0;
    end else begin
      if (fetch_vld) begin
        fetch_seen++;
        check("fetch_expected", fq.size() != 0, 1);
        if (fq.size() != 0) check("fetch_tile", fetch_tile, fq.pop_front());
      end
      if (mem_we) begin
        check("write_expected", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          mon_w = wq.pop_front();
          check("wr_addr", mem_addr, mon_w.a);
          check("wr_data", mem_wdata, mon_w.d);
          check("wr_gnt_with_we", wr_if.wr_gnt, mon_w.g);
        end
      end
      if (wr_if.wr_gnt) begin
        check("gnt_has_we", mem_we, 1);
        gnt_seen++;
        if (prev_gnt) gnt_adj++;
      end
      prev_gnt = wr_if.wr_gnt;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int k;
    int n;
    int g0;
    int a0;

    for (int i = 0; i < 2048; i++) begin
      ram[i]    = 4'(i * 7 + 3);
      shadow[i] = ram[i];
    end
    ram[41]    = 4'hA;
    shadow[41] = 4'hA;
    wr_if.wr_req  = 1'b0;
    wr_if.wr_addr = '0;
    wr_if.wr_data = '0;

    tbl.push_back('{15, 16, 1, 41});
    tbl.push_back('{799, 479, 1, -1});
    tbl.push_back('{799, 524, 1, 0});
    tbl.push_back('{639, 0, 1, -1});
    tbl.push_back('{623, 464, 1, 1199});
    tbl.push_back('{799, 15, 1, 40});
    tbl.push_back('{15, 480, 1, -1});
    tbl.push_back('{14, 16, 1, -1});
    tbl.push_back('{15, 16, 0, -1});
    tbl.push_back('{1023, 0, 1, -1});
    tbl.push_back('{47, 100, 1, 243});
    tbl.push_back('{783, 0, 1, -1});

    // Power-on reset
    step(2);
    check("rst_outs", {fetch_tile, fetch_vld, wr_if.wr_gnt, clear_busy, mem_addr, mem_we, mem_wdata}, 0);
    rst_n = 1'b1;
    step(2);

    // Reset in the middle of a fetch, with a write pending
    hcount = 10'd15; vcount = 10'd16; pix_en = 1'b1;
    step(1);
    pix_en = 1'b0; hcount = '0; vcount = '0;
    check("pre_rst_addr", mem_addr, 41);
    rst_n = 1'b0;
    wr_if.wr_req = 1'b1; wr_if.wr_addr = 11'd9; wr_if.wr_data = 4'd9;
    #1;
    check("async_rst_outs", {fetch_tile, fetch_vld, wr_if.wr_gnt, clear_busy, mem_addr, mem_we, mem_wdata}, 0);
    step(3);
    wr_if.wr_req = 1'b0;
    rst_n = 1'b1;
    step(10);
    check("no_vld_after_rst", fetch_seen, 0);

    // Fetch slot table
    foreach (tbl[i]) begin
      hcount = 10'(tbl[i].h); vcount = 10'(tbl[i].v); pix_en = tbl[i].pe[0];
      if (tbl[i].a >= 0) fq.push_back(shadow[tbl[i].a]);
      step(1);
      pix_en = 1'b0; hcount = '0; vcount = '0;
      if (tbl[i].a >= 0) begin
        check("fetch_addr", mem_addr, tbl[i].a);
        check("fetch_no_we", mem_we, 0);
      end
      step(1);
      check("vld_early", fetch_vld, 0);
      step(1);
      check("vld_n3", fetch_vld, tbl[i].a >= 0);
      step(1);
      check("vld_pulse", fetch_vld, 0);
      step(1);
    end

    // Write request colliding with a fetch slot
    hcount = 10'd15; vcount = 10'd16; pix_en = 1'b1;
    wr_if.wr_req = 1'b1; wr_if.wr_addr = 11'd5; wr_if.wr_data = 4'd3;
    fq.push_back(shadow[41]);
    push_wr(5, 3, 1'b1);
    shadow[5] = 4'd3;
    step(1);
    pix_en = 1'b0; hcount = '0; vcount = '0;
    check("cont_fetch_addr", mem_addr, 41);
    check("cont_no_early_we", mem_we, 0);
    got = 0;
    for (int j = 0; j < 3 && got == 0; j++) begin
      step(1);
      got = int'(wr_if.wr_gnt);
    end
    check("cont_gnt_within3", got, 1);
    wr_if.wr_req = 1'b0;
    step(4);

    // Back-to-back writes during vertical blank
    vcount = 10'd500; hcount = '0;
    g0 = gnt_seen; a0 = gnt_adj;
    k = 0;
    wr_if.wr_req = 1'b1; wr_if.wr_addr = 11'd600; wr_if.wr_data = 4'd0;
    push_wr(600, 0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (wr_if.wr_gnt && i < 98) begin
        k++;
        wr_if.wr_addr = 11'(600 + k);
        wr_if.wr_data = 4'(k);
        push_wr(600 + k, k, 1'b1);
      end
    end
    wr_if.wr_req = 1'b0;
    step(3);
    check("tput_gnts", gnt_seen - g0, 50);
    check("tput_adjacent", gnt_adj - a0, 0);

`ifdef TILE_ARB_CLEAR_EN
    for (int i = 0; i < 1200; i++) push_wr(i, 0, 1'b0);
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    check("clr_busy_rise", clear_busy, 1);
    step(100);
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    n = 0;
    while (clear_busy && n < 1500) begin
      step(1);
      n++;
    end
    check("clr_busy_fall", clear_busy, 0);
    check("clr_last_addr", {mem_we, mem_addr}, {1'b1, 11'd1199});
    step(2);
    check("clr_all_written", wq.size(), 0);
`else
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    check("clr_disabled_busy", clear_busy, 0);
    step(5);
`endif

    step(4);
    check("fetch_q_empty", fq.size(), 0);
    check("write_q_empty", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
